// File: rtl/top_level_types.sv
// Shared types for the writeback stage and its register-file write port.
package top_level_types;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef logic [DATA_W-1:0] unsigned_32;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LOAD = 2'd2
  } WbKindType;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4
  } MemOpType;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } WbStateType;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    unsigned_32       dstdata;
  } RegfileWriteType;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    WbKindType        kind;
    unsigned_32       alu_data;
    MemOpType         mem_op;
    logic [1:0]       addr_lo;
  } WbReqType;

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword/word of a load response and extends it.
module load_extract
  import top_level_types::*;
(
  input  MemOpType   mem_op,
  input  logic [1:0] addr_lo,
  input  unsigned_32 word,
  output unsigned_32 ext_data_c,
  output logic       misaligned_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select, then sign/zero extension and alignment check by op
  always_comb begin
    byte_v       = word[{addr_lo, 3'b000} +: 8];
    half_v       = addr_lo[1] ? word[31:16] : word[15:0];
    ext_data_c   = '0;
    misaligned_c = 1'b0;
    case (mem_op)
      LB:  ext_data_c = {{24{byte_v[7]}}, byte_v};
      LBU: ext_data_c = {24'h000000, byte_v};
      LH: begin
        ext_data_c   = {{16{half_v[15]}}, half_v};
        misaligned_c = addr_lo[0];
      end
      LHU: begin
        ext_data_c   = {16'h0000, half_v};
        misaligned_c = addr_lo[0];
      end
      LW: begin
        ext_data_c   = word;
        misaligned_c = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/writeback_iss.sv
// Writeback stage: retires ALU results and loads into the register file.
module writeback_iss
  import top_level_types::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_req_valid,
  output logic            wb_req_ready,
  input  WbReqType        wb_req,
  input  logic            mem_rsp_valid,
  input  unsigned_32      mem_rsp_data,
  output RegfileWriteType CtlToRegs_port,
  output logic            CtlToRegs_port_sync,
  output logic            wb_done,
  output logic            wb_err
);

  WbStateType      state_q, state_d;
  WbReqType        req_q, req_d;
  logic            ready_q, ready_d;
  RegfileWriteType port_q, port_d;
  logic            sync_q, sync_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            accept;
  MemOpType        ext_op;
  logic [1:0]      ext_lo;
  unsigned_32      ext_data;
  logic            ext_misaligned;

  assign accept = wb_req_valid & ready_q;

  // In IDLE the extractor checks the incoming request; afterwards it serves the latched load
  assign ext_op = (state_q == IDLE) ? wb_req.mem_op  : req_q.mem_op;
  assign ext_lo = (state_q == IDLE) ? wb_req.addr_lo : req_q.addr_lo;

  load_extract u_load_extract (
    .mem_op       (ext_op),
    .addr_lo      (ext_lo),
    .word         (mem_rsp_data),
    .ext_data_c   (ext_data),
    .misaligned_c (ext_misaligned)
  );

  // State and request registers; reset drops any in-flight load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= WbReqType'('0);
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // Next-state: route accepted requests, wait for memory, single write cycle
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = wb_req;
          if (wb_req.kind == WB_ALU) begin
            state_d = WRITE;
          end else if (wb_req.kind == WB_LOAD && !ext_misaligned) begin
            state_d = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: if (mem_rsp_valid) state_d = WRITE;
      WRITE:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output next values; writes to x0 keep the strobe low
  always_comb begin
    ready_d = (state_d == IDLE);
    port_d  = port_q;
    sync_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    if (mem_rsp_valid && state_q != WAIT_MEM) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (wb_req.kind)
            WB_ALU: begin
              port_d = '{dst: wb_req.dst, dstdata: wb_req.alu_data};
              sync_d = (wb_req.dst != '0);
              done_d = 1'b1;
            end
            WB_LOAD: begin
              if (ext_misaligned) begin
                err_d  = 1'b1;
                done_d = 1'b1;
              end
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid) begin
          port_d = '{dst: req_q.dst, dstdata: ext_data};
          sync_d = (req_q.dst != '0);
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b1;
      port_q  <= RegfileWriteType'('0);
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      port_q  <= port_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wb_req_ready        = ready_q;
  assign CtlToRegs_port      = port_q;
  assign CtlToRegs_port_sync = sync_q;
  assign wb_done             = done_q;
  assign wb_err              = err_q;

endmodule

// File: tb/tb_writeback_iss.sv
// Bench for writeback_iss: directed scenarios plus random traffic against a retire-level model.
module tb_writeback_iss;
  import top_level_types::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_req_valid;
  logic            wb_req_ready;
  WbReqType        wb_req;
  logic            mem_rsp_valid;
  unsigned_32      mem_rsp_data;
  RegfileWriteType CtlToRegs_port;
  logic            CtlToRegs_port_sync;
  logic            wb_done;
  logic            wb_err;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  writeback_iss dut (
    .clk                 (clk),
    .rst                 (rst),
    .wb_req_valid        (wb_req_valid),
    .wb_req_ready        (wb_req_ready),
    .wb_req              (wb_req),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .CtlToRegs_port      (CtlToRegs_port),
    .CtlToRegs_port_sync (CtlToRegs_port_sync),
    .wb_done             (wb_done),
    .wb_err              (wb_err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // busy: 0 = free, 1 = load waiting for memory, 2 = retiring this cycle
  int              m_busy = 0;
  WbReqType        m_pend;
  RegfileWriteType m_port;
  bit              m_sync, m_done, m_err;

  function automatic unsigned_32 ref_load(input MemOpType op, input logic [1:0] a, input unsigned_32 w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * (a / 2))) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? b + 32'hFFFFFF00 : b;
      LBU:     return b;
      LH:      return (h >= 32768) ? h + 32'hFFFF0000 : h;
      LHU:     return h;
      LW:      return w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_misaligned(input MemOpType op, input logic [1:0] a);
    if (op == LH || op == LHU) return (a % 2) != 0;
    if (op == LW) return a != 0;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_port = '0; m_sync = 0; m_done = 0; m_err = 0; m_pend = '0;
      end else begin
        m_sync = 0;
        m_done = 0;
        if (mem_rsp_valid && m_busy != 1) m_err = 1;
        if (m_busy == 2) begin
          m_busy = 0;
        end else if (m_busy == 1) begin
          if (mem_rsp_valid) begin
            m_port.dst     = m_pend.dst;
            m_port.dstdata = ref_load(m_pend.mem_op, m_pend.addr_lo, mem_rsp_data);
            m_sync = (m_pend.dst != 0);
            m_done = 1;
            m_busy = 2;
          end
        end else if (wb_req_valid) begin
          if (wb_req.kind == WB_ALU) begin
            m_port.dst     = wb_req.dst;
            m_port.dstdata = wb_req.alu_data;
            m_sync = (wb_req.dst != 0);
            m_done = 1;
            m_busy = 2;
          end else if (wb_req.kind == WB_LOAD) begin
            if (ref_misaligned(wb_req.mem_op, wb_req.addr_lo)) begin
              m_err  = 1;
              m_done = 1;
            end else begin
              m_pend = wb_req;
              m_busy = 1;
            end
          end else begin
            m_done = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison just after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check("ready", wb_req_ready, m_busy == 0);
        check("sync", CtlToRegs_port_sync, m_sync);
        check("done", wb_done, m_done);
        check("err", wb_err, m_err);
        check("port", CtlToRegs_port, m_port);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic WbReqType mk(input logic [4:0] d, input WbKindType k, input unsigned_32 a,
                                  input MemOpType op, input logic [1:0] lo);
    WbReqType r;
    r.dst = d; r.kind = k; r.alu_data = a; r.mem_op = op; r.addr_lo = lo;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge of the first cycle after acceptance
  task automatic accept(input WbReqType r);
    int n = 0;
    while (!wb_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 0, 1);
    wb_req_valid = 1'b1;
    wb_req       = r;
    @(negedge clk);
    wb_req_valid = 1'b0;
  endtask

  // Response in the delay-th wait cycle; returns in the write cycle
  task automatic load_rsp(input int delay, input unsigned_32 d);
    for (int i = 1; i < delay; i++) @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = d;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int low_cnt, sync_at;
    unsigned_32 sync_data;
    WbReqType r;
    bit ld;

    rst = 1'b1; wb_req_valid = 1'b0; wb_req = '0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", wb_req_ready, 1);
    check("rst_sync", CtlToRegs_port_sync, 0);
    check("rst_done", wb_done, 0);
    check("rst_err", wb_err, 0);
    check("rst_port", CtlToRegs_port, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // ALU to x5
    accept(mk(5'd5, WB_ALU, 32'hDEADBEEF, LW, 2'd0));
    check("alu_sync", CtlToRegs_port_sync, 1);
    check("alu_dst", CtlToRegs_port.dst, 5);
    check("alu_data", CtlToRegs_port.dstdata, 32'hDEADBEEF);
    check("alu_done", wb_done, 1);
    @(negedge clk);
    check("alu_sync_off", CtlToRegs_port_sync, 0);
    check("alu_ready_back", wb_req_ready, 1);

    // Byte/halfword extraction
    accept(mk(5'd7, WB_LOAD, 32'h0, LB, 2'd3));
    load_rsp(2, 32'h80112233);
    check("lb_sync", CtlToRegs_port_sync, 1);
    check("lb_data", CtlToRegs_port.dstdata, 32'hFFFFFF80);
    accept(mk(5'd8, WB_LOAD, 32'h0, LBU, 2'd3));
    load_rsp(1, 32'h80112233);
    check("lbu_data", CtlToRegs_port.dstdata, 32'h00000080);
    accept(mk(5'd9, WB_LOAD, 32'h0, LHU, 2'd2));
    load_rsp(3, 32'hBEEF1234);
    check("lhu_data", CtlToRegs_port.dstdata, 32'h0000BEEF);
    check("lhu_dst", CtlToRegs_port.dst, 9);

    // ALU to x0: retire without strobe
    accept(mk(5'd0, WB_ALU, 32'h12345678, LW, 2'd0));
    check("x0_done", wb_done, 1);
    check("x0_sync", CtlToRegs_port_sync, 0);
    @(negedge clk);
    check("x0_sync_after", CtlToRegs_port_sync, 0);

    // Misaligned LW
    accept(mk(5'd3, WB_LOAD, 32'h0, LW, 2'd2));
    check("mis_err", wb_err, 1);
    check("mis_done", wb_done, 1);
    check("mis_sync", CtlToRegs_port_sync, 0);
    check("mis_ready", wb_req_ready, 1);
    pulse_reset();

    // Stray response in IDLE
    check("stray_err_pre", wb_err, 0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("stray_err", wb_err, 1);
    pulse_reset();

    // Reset while waiting for memory; response arrives during reset
    accept(mk(5'd11, WB_LOAD, 32'h0, LW, 2'd0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_ready", wb_req_ready, 1);
    check("rstw_err", wb_err, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11112222;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready_after", wb_req_ready, 1);
    check("rstw_sync_after", CtlToRegs_port_sync, 0);
    check("rstw_err_after", wb_err, 0);

    // LW with a 5-cycle memory delay
    accept(mk(5'd12, WB_LOAD, 32'h0, LW, 2'd0));
    low_cnt = 0; sync_at = 0; sync_data = '0;
    for (int i = 1; i <= 8; i++) begin
      if (!wb_req_ready) low_cnt++;
      if (CtlToRegs_port_sync) begin
        sync_at   = i;
        sync_data = CtlToRegs_port.dstdata;
      end
      mem_rsp_valid = (i == 5);
      mem_rsp_data  = 32'hCAFEF00D;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    check("lw5_ready_low_cycles", low_cnt, 6);
    check("lw5_sync_cycle", sync_at, 6);
    check("lw5_data", sync_data, 32'hCAFEF00D);

    // Random traffic
    repeat (300) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_rsp_valid = ($urandom_range(0, 7) == 0);
        mem_rsp_data  = $urandom;
        @(negedge clk);
      end
      mem_rsp_valid = 1'b0;
      r = mk(5'($urandom_range(0, 31)), WbKindType'($urandom_range(0, 2)), $urandom,
             MemOpType'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      ld = (r.kind == WB_LOAD) && !ref_misaligned(r.mem_op, r.addr_lo);
      mem_rsp_valid = ld && ($urandom_range(0, 9) == 0);
      mem_rsp_data  = $urandom;
      accept(r);
      mem_rsp_valid = 1'b0;
      if (ld) begin
        if ($urandom_range(0, 25) == 0) pulse_reset();
        else load_rsp($urandom_range(1, 4), $urandom);
      end else if ($urandom_range(0, 40) == 0) begin
        pulse_reset();
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_iss.md
# writeback_ISS

Writeback stage of the RISC-V ISS core, directly upstream of the register file. Accepts one retire request at a time from the control unit: an ALU result, a load awaiting memory data, or a no-write instruction. For loads it waits for the memory response, extracts and extends the addressed byte, halfword or word, and issues a single-cycle write strobe on the register-file write port. Writes to x0 are suppressed, and misaligned loads are flagged instead of being written.

## Interface
- No parameters. The data width is fixed at 32 and the register index at 5 bits, via package types.
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- wb_req_valid  in  1  control unit offers a retire request.
- wb_req_ready  out  1  stage can accept; high only in IDLE.
- wb_req  in  WbReqType  fields:
  - dst[4:0]
  - kind: WB_NONE, WB_ALU or WB_LOAD
  - alu_data[31:0]
  - mem_op: LB, LH, LW, LBU or LHU
  - addr_lo[1:0]
- mem_rsp_valid  in  1  load data present this cycle.
- mem_rsp_data  in  32  aligned memory word.
- CtlToRegs_port  out  RegfileWriteType  {dst, dstdata} to the register file.
- CtlToRegs_port_sync  out  1  write strobe to the register file.
- wb_done  out  1  one-cycle pulse when a request retires.
- wb_err  out  1  sticky flag: misaligned load or unexpected memory response. Cleared only by rst.

## Operation
- States are IDLE, WAIT_MEM and WRITE. A request is accepted when wb_req_valid and wb_req_ready are both high; the stage latches the whole wb_req.
- IDLE, on accept:
  - WB_ALU → WRITE, with dstdata = alu_data.
  - WB_LOAD, aligned → WAIT_MEM.
  - WB_LOAD, misaligned → set wb_err, pulse wb_done the next cycle, no write, stay in IDLE. Misaligned means LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0.
  - WB_NONE → pulse wb_done the next cycle, stay in IDLE.
- WAIT_MEM: when mem_rsp_valid is high, compute dstdata and go to WRITE.
  - LB/LBU: byte mem_rsp_data[8*addr_lo +: 8], sign- or zero-extended.
  - LH/LHU: halfword mem_rsp_data[16*addr_lo[1] +: 16], sign- or zero-extended.
  - LW: the full word.
- WRITE: drive CtlToRegs_port_sync=1 for exactly one cycle, with dst and dstdata stable; pulse wb_done in the same cycle; return to IDLE.
- dst==0: the stage still passes through WRITE and pulses wb_done, but holds CtlToRegs_port_sync at 0.
- A mem_rsp_valid outside WAIT_MEM is ignored and sets wb_err.
- CtlToRegs_port holds its last value between writes. Only the sync strobe qualifies it.

## Timing
- All outputs are registered. Reset values:
  - state IDLE, wb_req_ready 1
  - CtlToRegs_port {0,0}, CtlToRegs_port_sync 0
  - wb_done 0, wb_err 0
- ALU latency: accept at edge N; sync and wb_done are high in cycle N+1; ready returns in cycle N+2.
- Load latency: mem_rsp_valid sampled at edge M; sync is high in cycle M+1. WAIT_MEM has no timeout.
- WB_NONE and misaligned loads: wb_done is high in the cycle after acceptance; ready stays high, so back-to-back acceptance is allowed.
- wb_req_ready is low in WAIT_MEM and WRITE. Peak throughput is one ALU retire every 2 cycles.
- mem_rsp_valid in the same cycle as acceptance of a load: the response is ignored and wb_err is set. The response must arrive in WAIT_MEM.
- rst mid-operation: an in-flight load is dropped, no write is issued, and all outputs return to their reset values at once.

## Structure
- top_level_types package:
  - WbReqType, WbKindType and MemOpType enums
  - existing RegfileWriteType and unsigned_32
- Sub-module load_extract: purely combinational. Inputs mem_op, addr_lo, word; outputs the extended 32-bit value and a misaligned flag.

## Test plan
- ALU to x5, data 0xDEADBEEF → one cycle after accept, sync=1 with dst=5, dstdata=0xDEADBEEF, and wb_done=1; sync=0 the next cycle.
- LB with addr_lo=3, rsp 0x80112233 → dstdata 0xFFFFFF80. LBU, same inputs → 0x00000080. LHU with addr_lo=2, rsp 0xBEEF1234 → 0x0000BEEF.
- ALU to x0, data 0x12345678 → wb_done=1, sync stays 0 throughout.
- LW with addr_lo=2 → wb_err=1, no sync, wb_done in the next cycle. A stray mem_rsp_valid in IDLE → wb_err=1.
- Load accepted, rst asserted in WAIT_MEM, then mem_rsp_valid → state IDLE, no sync, wb_err=0 after reset.
- LW with a 5-cycle memory delay, rsp 0xCAFEF00D → ready=0 for 6 cycles; sync the cycle after the response with dstdata 0xCAFEF00D.
